// File: rtl/mux_8to1_if.sv
// Bus bundle for the registered 8-to-1 selector: load enable, eight data candidates,
// select, and the registered result with its select tag and valid flag.
interface mux_8to1_if #(
    parameter int unsigned WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;
    logic [WIDTH-1:0] d5;
    logic [WIDTH-1:0] d6;
    logic [WIDTH-1:0] d7;
    logic [2:0]       s;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic [2:0]       sel_q;

    modport master (
        output en, d0, d1, d2, d3, d4, d5, d6, d7, s,
        input  y, valid, sel_q
    );

    modport slave (
        input  en, d0, d1, d2, d3, d4, d5, d6, d7, s,
        output y, valid, sel_q
    );
endinterface

// File: rtl/mux_8to1.sv
// Registered 8-to-1 word selector with load enable; valid marks the cycle after a load
// and sel_q records which input was captured.
module mux_8to1 #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    mux_8to1_if.slave   bus
);
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] y_d, y_q;
    logic [2:0]       sel_cap_d, sel_cap_q;
    logic             valid_d, valid_q;

    // All eight codes map to a data input, so the case is full without a default arm.
    always_comb begin
        sel_data = bus.d0;
        case (bus.s)
            3'b000: sel_data = bus.d0;
            3'b001: sel_data = bus.d1;
            3'b010: sel_data = bus.d2;
            3'b011: sel_data = bus.d3;
            3'b100: sel_data = bus.d4;
            3'b101: sel_data = bus.d5;
            3'b110: sel_data = bus.d6;
            3'b111: sel_data = bus.d7;
        endcase
    end

    always_comb begin
        y_d       = y_q;
        sel_cap_d = sel_cap_q;
        valid_d   = 1'b0;
        if (bus.en) begin
            y_d       = sel_data;
            sel_cap_d = bus.s;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            sel_cap_q <= 3'b000;
            valid_q   <= 1'b0;
        end else begin
            y_q       <= y_d;
            sel_cap_q <= sel_cap_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.sel_q = sel_cap_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: expected results are queued when stimulus is driven
// and compared against the registered outputs after the capturing edge.
module tb_mux_8to1;
    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [2:0]       sel;
        logic             valid;
    } exp_t;

    logic clk;
    logic rst;
    logic [WIDTH-1:0] d_arr [8];

    int tests_run;
    int tests_failed;

    exp_t exp_q[$];
    logic [WIDTH-1:0] m_y;
    logic [2:0]       m_sel;
    logic             m_valid;

    mux_8to1_if #(.WIDTH(WIDTH)) bus ();

    assign bus.d0 = d_arr[0];
    assign bus.d1 = d_arr[1];
    assign bus.d2 = d_arr[2];
    assign bus.d3 = d_arr[3];
    assign bus.d4 = d_arr[4];
    assign bus.d5 = d_arr[5];
    assign bus.d6 = d_arr[6];
    assign bus.d7 = d_arr[7];

    mux_8to1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_y     = '0;
        m_sel   = 3'b000;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // Drive is assumed settled (called at a negedge); one capturing edge is taken.
    task automatic step(input string tag);
        exp_t e;
        if (bus.en) begin
            m_y     = d_arr[bus.s];
            m_sel   = bus.s;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        exp_q.push_back('{y: m_y, sel: m_sel, valid: m_valid});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_y"}, 32'(bus.y), 32'(e.y));
            check_eq({tag, "_sel_q"}, 32'(bus.sel_q), 32'(e.sel));
            check_eq({tag, "_valid"}, 32'(bus.valid), 32'(e.valid));
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.s        = 3'd3;
        for (int k = 0; k < 8; k++) d_arr[k] = 16'(k);
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_y", 32'(bus.y), 32'h0);
        check_eq("rst_async_sel", 32'(bus.sel_q), 32'h0);
        check_eq("rst_async_valid", 32'(bus.valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_y", 32'(bus.y), 32'h0);
        check_eq("rst_hold_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Select sweep
        for (int k = 0; k < 8; k++) begin
            bus.s = 3'(k);
            step("sweep");
        end

        // Select toggle 000/111
        d_arr[0] = 16'h0000;
        d_arr[7] = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            bus.s = (i % 2 == 0) ? 3'b000 : 3'b111;
            step("toggle");
        end

        // Data isolation: only d2 is selected, others toggle between value and complement
        for (int k = 0; k < 8; k++) d_arr[k] = 16'(k);
        bus.s = 3'd2;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) if (k != 2) d_arr[k] = ~d_arr[k];
            step("isolate");
            check_eq("isolate_const", 32'(bus.y), 32'h0002);
        end
        d_arr[2] = 16'hFFFD;
        step("fullwidth");
        check_eq("fullwidth_const", 32'(bus.y), 32'hFFFD);

        // Enable hold
        bus.s    = 3'd4;
        d_arr[4] = 16'h0004;
        step("load4");
        bus.en   = 1'b0;
        bus.s    = 3'd5;
        d_arr[4] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            check_eq("hold_y_const", 32'(bus.y), 32'h0004);
            check_eq("hold_sel_const", 32'(bus.sel_q), 32'h4);
        end
        bus.en = 1'b1;
        step("reenable");

        // Mid-stream reset pulse between edges during a sweep
        for (int k = 0; k < 8; k++) d_arr[k] = 16'(k) + 16'h0A00;
        for (int k = 0; k < 8; k++) begin
            bus.s = 3'(k);
            if (k == 4) begin
                rst = 1'b1;
                #1;
                check_eq("midrst_y", 32'(bus.y), 32'h0);
                check_eq("midrst_sel", 32'(bus.sel_q), 32'h0);
                check_eq("midrst_valid", 32'(bus.valid), 32'h0);
                #1 rst = 1'b0;
                model_reset();
            end
            step("sweep2");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
